// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: start, 8 data bits LSB-first, optional parity, one stop bit
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   i_tx_start  transmit request, accepted when not busy
//   i_tx_d      byte to send, captured on accept
//   o_tx_d      registered serial line, idle high
//   o_tx_busy   high while a frame is in progress
//   o_tx_done   one-cycle pulse after the stop bit
module uart_tx_core #(
  parameter int SYS_CLK   = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_d,
  output logic       o_tx_d,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int BIT_DIV = SYS_CLK / BAUD_RATE;
  localparam int CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  // Unsupported parity codes fall back to no parity.
  localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_nxt;
  logic             par_bit;
  logic             tx_d_q;
  logic             tx_d_nxt;
  logic             tx_done_q;
  logic             accept;
  logic             baud_end;

  assign accept   = (state == S_IDLE) && i_tx_start;
  assign baud_end = (baud_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    tx_d_nxt  = 1'b1;
    case (state)
      S_IDLE: begin
        if (i_tx_start) begin
          state_nxt = S_START;
          shift_nxt = i_tx_d;
        end
      end
      S_START: begin
        if (baud_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (baud_end) begin
          shift_nxt = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) state_nxt = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (baud_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (baud_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // The line value is decided from the state being entered so that the
    // output flop changes on the same edge as the state register.
    case (state_nxt)
      S_START:  tx_d_nxt = 1'b0;
      S_DATA:   tx_d_nxt = shift_nxt[0];
      S_PARITY: tx_d_nxt = par_bit;
      default:  tx_d_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx_d_q    <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      tx_d_q    <= tx_d_nxt;
      tx_done_q <= (state == S_STOP) && baud_end;

      if ((state == S_IDLE) || baud_end) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + CNT_W'(1);

      if (state != S_DATA) bit_idx <= '0;
      else if (baud_end)   bit_idx <= bit_idx + 3'd1;

      if (accept) par_bit <= (^i_tx_d) ^ PAR_ODD;
    end
  end

  assign o_tx_d    = tx_d_q;
  assign o_tx_busy = (state != S_IDLE);
  assign o_tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed table-driven bench for uart_tx_core at BIT_DIV = 16
module tb_uart_tx_core;

  localparam int BD = 16;

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic [10:0] frame;
    int         nbits;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] start;
  logic [7:0] data [3];
  logic [2:0] txd;
  logic [2:0] busy;
  logic [2:0] done;

  int tests_run;
  int tests_failed;

  vec_t vecs [12];

  uart_tx_core #(.SYS_CLK(1600), .BAUD_RATE(100), .PARITY(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[0]), .i_tx_d(data[0]),
    .o_tx_d(txd[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0])
  );

  uart_tx_core #(.SYS_CLK(1600), .BAUD_RATE(100), .PARITY(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[1]), .i_tx_d(data[1]),
    .o_tx_d(txd[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1])
  );

  uart_tx_core #(.SYS_CLK(1600), .BAUD_RATE(100), .PARITY(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[2]), .i_tx_d(data[2]),
    .o_tx_d(txd[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge while the request for byte b is being presented.
  // Checks every cycle of the frame, then the done cycle. With hold set, the
  // request stays high and next_b is presented in the done cycle.
  task automatic run_frame(input int sel, input logic [7:0] b, input logic [10:0] exp,
                           input int nbits, input bit hold, input logic [7:0] next_b,
                           input int reject_at);
    int f;
    int line_err;
    int busy_cnt;
    int done_cnt;
    f        = nbits * BD;
    line_err = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      if (txd[sel] !== exp[c / BD]) line_err++;
      if (busy[sel] === 1'b1) busy_cnt++;
      if (done[sel] !== 1'b0) done_cnt++;
      if (c == 0) begin
        data[sel] = ~b;
        if (!hold) start[sel] = 1'b0;
      end
      if (reject_at >= 0 && c == reject_at) begin
        start[sel] = 1'b1;
        data[sel]  = 8'h3C;
      end
      if (reject_at >= 0 && c == reject_at + 1) start[sel] = 1'b0;
    end
    chk($sformatf("line_err_cycles[%0d:%02h]", sel, b), line_err, 0);
    chk($sformatf("busy_cycles[%0d:%02h]", sel, b), busy_cnt, f);
    chk($sformatf("done_in_frame[%0d:%02h]", sel, b), done_cnt, 0);
    @(negedge clk);
    chk($sformatf("done_pulse[%0d:%02h]", sel, b), int'(done[sel]), 1);
    chk($sformatf("busy_at_done[%0d:%02h]", sel, b), int'(busy[sel]), 0);
    chk($sformatf("line_at_done[%0d:%02h]", sel, b), int'(txd[sel]), 1);
    if (hold) begin
      data[sel] = next_b;
    end else begin
      @(negedge clk);
      chk($sformatf("done_cleared[%0d:%02h]", sel, b), int'(done[sel]), 0);
      chk($sformatf("idle_line[%0d:%02h]", sel, b), int'(txd[sel]), 1);
    end
  endtask

  initial begin
    int lows;
    int pulses;
    int busys;
    tests_run    = 0;
    tests_failed = 0;

    // Frames are LSB-first: bit0 start, bits 1..8 data, then parity (if any), then stop.
    vecs[0]  = '{0, 8'hA5, 11'h34A, 10};
    vecs[1]  = '{1, 8'h07, 11'h60E, 11};
    vecs[2]  = '{2, 8'h07, 11'h40E, 11};
    vecs[3]  = '{0, 8'h00, 11'h200, 10};
    vecs[4]  = '{0, 8'hFF, 11'h3FE, 10};
    vecs[5]  = '{0, 8'h81, 11'h302, 10};
    vecs[6]  = '{0, 8'h5A, 11'h2B4, 10};
    vecs[7]  = '{1, 8'h00, 11'h400, 11};
    vecs[8]  = '{2, 8'h00, 11'h600, 11};
    vecs[9]  = '{1, 8'hFF, 11'h5FE, 11};
    vecs[10] = '{2, 8'hFF, 11'h7FE, 11};
    vecs[11] = '{2, 8'h81, 11'h702, 11};

    rst_n = 1'b0;
    start = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_line[%0d]", i), int'(txd[i]), 1);
      chk($sformatf("reset_busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("reset_done[%0d]", i), int'(done[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      start[vecs[v].sel] = 1'b1;
      data[vecs[v].sel]  = vecs[v].d;
      run_frame(vecs[v].sel, vecs[v].d, vecs[v].frame, vecs[v].nbits, 1'b0, 8'h00, -1);
    end

    // Back-to-back under a continuously held request.
    start[0] = 1'b1;
    data[0]  = 8'h00;
    run_frame(0, 8'h00, 11'h200, 10, 1'b1, 8'hFF, -1);
    run_frame(0, 8'hFF, 11'h3FE, 10, 1'b0, 8'h00, -1);

    // Request while busy is dropped and not queued.
    start[0] = 1'b1;
    data[0]  = 8'h55;
    run_frame(0, 8'h55, 11'h2AA, 10, 1'b0, 8'h00, 40);
    lows  = 0;
    busys = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
      if (busy[0] !== 1'b0) busys++;
    end
    chk("reject_no_second_frame_line", lows, 0);
    chk("reject_no_second_frame_busy", busys, 0);

    // Reset during the stop bit.
    start[0] = 1'b1;
    data[0]  = 8'h12;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (c == 0) start[0] = 1'b0;
    end
    chk("pre_reset_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_stop_line", int'(txd[0]), 1);
    chk("rst_mid_stop_busy", int'(busy[0]), 0);
    chk("rst_mid_stop_done", int'(done[0]), 0);
    rst_n  = 1'b1;
    lows   = 0;
    pulses = 0;
    busys  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
      if (done[0] !== 1'b0) pulses++;
      if (busy[0] !== 1'b0) busys++;
    end
    chk("post_rst_line_low_cycles", lows, 0);
    chk("post_rst_done_pulses", pulses, 0);
    chk("post_rst_busy_cycles", busys, 0);

    // Reset and request in the same cycle: reset wins.
    rst_n    = 1'b0;
    start[0] = 1'b1;
    data[0]  = 8'h00;
    @(negedge clk);
    chk("rst_vs_start_busy", int'(busy[0]), 0);
    chk("rst_vs_start_line", int'(txd[0]), 1);
    rst_n    = 1'b1;
    start[0] = 1'b0;
    @(negedge clk);
    chk("rst_vs_start_still_idle", int'(busy[0]), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

UART transmitter that serialises one 8-bit byte per request into a standard asynchronous frame: start bit, 8 data bits LSB-first, optional parity bit, and one stop bit. It is the transmit-side counterpart of the team's UART receiver and uses the same system clock and baud parameters, so a Tx/Rx pair can be looped back directly. Bit timing comes from an internal baud-tick counter. A simple start/busy/done handshake faces the user logic.

## Interface
- SYS_CLK, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, line bit rate in bit/s
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd; any other value is treated as 0
- clk  input  1  system clock; all logic is on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- i_tx_start  input  1  transmit request, sampled every cycle
- i_tx_d  input  8  byte to send; sampled only in the cycle a request is accepted
- o_tx_d  output  1  serial line, idle high
- o_tx_busy  output  1  high while a frame is in progress
- o_tx_done  output  1  one-cycle pulse at the end of the stop bit

## Operation
- Bit period: BIT_DIV = SYS_CLK / BAUD_RATE, using integer (truncating) division. This is 434 at the default values. The baud counter is ceil(log2(BIT_DIV)) bits wide and counts 0..BIT_DIV-1.
- The baud counter is held at 0 in IDLE. It restarts at 0 on every bit boundary, so every bit lasts exactly BIT_DIV cycles.
- Accept rule: a request is accepted when i_tx_start = 1 in a cycle where o_tx_busy = 0. In that cycle i_tx_d is copied into an internal shift register, and the parity bit is computed from i_tx_d.
- Requests made while o_tx_busy = 1 are ignored. They are not queued.
- States:
  - IDLE: o_tx_d = 1. On accept, go to START.
  - START: o_tx_d = 0 for BIT_DIV cycles, then go to DATA.
  - DATA: o_tx_d = shift_reg[0]. At the end of each bit, shift right and increment a 3-bit bit index. After bit index 7 completes, go to PARITY if PARITY is 1 or 2, otherwise go to STOP.
  - PARITY: o_tx_d = XOR of the 8 data bits for even mode, or its inverse for odd mode, for BIT_DIV cycles, then go to STOP.
  - STOP: o_tx_d = 1 for BIT_DIV cycles, then go to IDLE and pulse o_tx_done.
- o_tx_d is driven from a flop, with no combinational path from the inputs. It carries no glitches.
- o_tx_busy = 1 in every state except IDLE.
- Reset, including reset mid-frame: the next edge forces o_tx_d = 1, o_tx_busy = 0, o_tx_done = 0, state IDLE, baud counter 0, bit index 0. The partial frame is abandoned, and the line simply returns to idle-high.
- i_tx_start held high continuously: each frame is accepted in the first cycle that o_tx_busy is low. This produces back-to-back frames.
- i_tx_start and rst_n = 0 in the same cycle: reset wins and nothing is accepted.

## Timing
- Reset values: o_tx_d = 1, o_tx_busy = 0, o_tx_done = 0.
- Accept at edge N: from edge N+1, o_tx_d = 0 (start bit) and o_tx_busy = 1.
- Data bit k is driven from edge N+1+(k+1)·BIT_DIV.
- Frame length F = (10 + P)·BIT_DIV cycles, where P = 1 if parity is enabled, else 0.
- At edge N+1+F:
  - state returns to IDLE;
  - o_tx_busy = 0 and o_tx_done = 1 for exactly one cycle;
  - o_tx_d stays 1.
- Back-to-back: a request present in the o_tx_done cycle is accepted at that edge. The next start bit begins one cycle after the previous stop bit ends, so the stop bit is effectively BIT_DIV+1 cycles long. There is never a gap longer than 1 cycle under continuous start.
- Changes to i_tx_d outside the accept cycle have no effect on the frame in progress.

## Test plan
- Reset mid-STOP, then idle: assert rst_n = 0 for 1 cycle during the STOP bit -> next cycle o_tx_d = 1, o_tx_busy = 0, o_tx_done = 0, and the line stays high with no pulse on o_tx_done.
- Single byte, SYS_CLK = 1600, BAUD_RATE = 100 (BIT_DIV = 16), PARITY = 0: send 0xA5 -> line shows 0, 1,0,1,0,0,1,0,1, 1, with each bit exactly 16 cycles; o_tx_busy is high for 160 cycles; o_tx_done pulses once at cycle 161 after accept.
- Parity modes: send 0x07 with PARITY = 1 -> parity bit = 1. Send 0x07 with PARITY = 2 -> parity bit = 0. In both cases the frame is 176 cycles.
- Busy rejection: pulse i_tx_start with 0x3C at cycle 40 of a 0x55 frame -> the 0x55 frame is unaltered and no second frame follows.
- Back-to-back: hold i_tx_start high with 0x00 then 0xFF -> the second start bit begins exactly 1 cycle after the first frame's 16-cycle stop bit; o_tx_done pulses once per frame.
- Loopback: connect o_tx_d to the team's UART receiver with matching parameters, and send 0x00, 0xFF, 0x81, 0x5A -> the receiver outputs identical bytes with no error flag.
